// File: rtl/if_id_pipe_pkg.sv
// Shared definitions for the IF/ID pipeline register: default widths,
// the NOP encoding, occupancy state encodings and the reset level.
package if_id_pipe_pkg;

  localparam int          AddrWDef  = 32;
  localparam int          InstWDef  = 32;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// Generic data+valid holding register with synchronous load and clear.
// Clear wins over load; both payload and valid return to zero on clear/reset.
module pipe_skid_slot
  import if_id_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  // slot payload and occupancy
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      q     <= {W{1'b0}};
      valid <= 1'b0;
    end else if (clr) begin
      q     <= {W{1'b0}};
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else begin
      q     <= q;
      valid <= valid;
    end
  end

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with a one-entry skid buffer, registered if_ready
// and synchronous flush. Optional backpressure counter under IFID_STALL_CNT_EN.
module if_id_pipe
  import if_id_pipe_pkg::*;
#(
  parameter int                ADDR_W   = AddrWDef,
  parameter int                INST_W   = InstWDef,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(ZeroWord)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int SLOT_W = ADDR_W + INST_W;

  pipe_state_e       state_r;
  pipe_state_e       state_s;
  logic              in_s;
  logic              out_s;
  logic              main_ld_s;
  logic              main_sk_s;
  logic              main_clr_s;
  logic              sk_ld_s;
  logic              sk_clr_s;
  logic              sk_valid_s;
  logic [SLOT_W-1:0] sk_data_s;
  logic [ADDR_W-1:0] sk_pc_s;
  logic [INST_W-1:0] sk_inst_s;

  // if_ready comes straight off the skid-valid flop, so decode never reaches fetch
  assign if_ready              = ~sk_valid_s;
  assign in_s                  = if_valid & if_ready;
  assign out_s                 = id_valid & id_ready;
  assign {sk_pc_s, sk_inst_s}  = sk_data_s;

  // occupancy state register
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state and datapath control; flush overrides any handshake
  always_comb begin
    state_s    = state_r;
    main_ld_s  = 1'b0;
    main_sk_s  = 1'b0;
    main_clr_s = 1'b0;
    sk_ld_s    = 1'b0;
    sk_clr_s   = 1'b0;
    if (flush) begin
      state_s    = ST_EMPTY;
      main_clr_s = 1'b1;
      sk_clr_s   = 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_s) begin
            main_ld_s = 1'b1;
            state_s   = ST_ONE;
          end else begin
            state_s   = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_s && out_s) begin
            main_ld_s  = 1'b1;
            state_s    = ST_ONE;
          end else if (in_s) begin
            sk_ld_s    = 1'b1;
            state_s    = ST_FULL;
          end else if (out_s) begin
            main_clr_s = 1'b1;
            state_s    = ST_EMPTY;
          end else begin
            state_s    = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_s) begin
            main_sk_s = 1'b1;
            sk_clr_s  = 1'b1;
            state_s   = ST_ONE;
          end else begin
            state_s   = ST_FULL;
          end
        end
        default: begin
          state_s    = ST_EMPTY;
          main_clr_s = 1'b1;
          sk_clr_s   = 1'b1;
        end
      endcase
    end
  end

  // main register driving decode; idle payload is forced to 0/NOP
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      id_valid <= 1'b0;
      id_pc    <= {ADDR_W{1'b0}};
      id_inst  <= NOP_INST;
    end else if (main_clr_s) begin
      id_valid <= 1'b0;
      id_pc    <= {ADDR_W{1'b0}};
      id_inst  <= NOP_INST;
    end else if (main_sk_s) begin
      id_valid <= 1'b1;
      id_pc    <= sk_pc_s;
      id_inst  <= sk_inst_s;
    end else if (main_ld_s) begin
      id_valid <= 1'b1;
      id_pc    <= if_pc;
      id_inst  <= if_inst;
    end else begin
      id_valid <= id_valid;
      id_pc    <= id_pc;
      id_inst  <= id_inst;
    end
  end

  pipe_skid_slot #(
    .W (SLOT_W)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clr   (sk_clr_s),
    .load  (sk_ld_s),
    .d     ({if_pc, if_inst}),
    .q     (sk_data_s),
    .valid (sk_valid_s)
  );

`ifdef IFID_STALL_CNT_EN
  // saturating backpressure counter; only reset clears it, flush does not
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      stall_cnt <= 16'h0000;
    end else if (id_valid && !id_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Scoreboard bench for if_id_pipe: accepted fetch beats are queued and
// compared in order against every decode transfer.
module tb_if_id_pipe;

  localparam int AW = 32;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          if_valid;
  logic          if_ready;
  logic [AW-1:0] if_pc;
  logic [IW-1:0] if_inst;
  logic          id_valid;
  logic          id_ready;
  logic [AW-1:0] id_pc;
  logic [IW-1:0] id_inst;
`ifdef IFID_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int          total = 0;
  int          bad   = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  if_id_pipe #(
    .ADDR_W   (AW),
    .INST_W   (IW),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_pc    (id_pc),
    .id_inst  (id_inst)
`ifdef IFID_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // one clock: drive at negedge, score just before posedge, return at next negedge
  task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                      input logic fl, input logic rs);
    logic [63:0] e;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst_of(pc);
    id_ready = rdy;
    flush    = fl;
    rst      = rs;
    #4;
    if (rs || fl) begin
      sb.delete();
    end else begin
      if (id_valid === 1'b0) begin
        check_eq("idle_pc", id_pc, 32'h0);
        check_eq("idle_inst", id_inst, 32'h0);
      end
      if (id_valid && rdy) begin
        if (sb.size() == 0) begin
          check_eq("sb_occupancy", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check_eq("out_pc", id_pc, e[63:32]);
          check_eq("out_inst", id_inst, e[31:0]);
        end
      end
      if (v && if_ready) sb.push_back({pc, inst_of(pc)});
    end
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_id_valid"}, 32'(id_valid), 32'd0);
    check_eq({tag, "_if_ready"}, 32'(if_ready), 32'd1);
    check_eq({tag, "_id_pc"}, id_pc, 32'h0);
    check_eq({tag, "_id_inst"}, id_inst, 32'h0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_pc = 32'h0; if_inst = 32'h0;
    @(negedge clk);

    // 1: reset then streaming
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_reset_vals("rst");
    step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    check_eq("lat1_valid", 32'(id_valid), 32'd1);
    check_eq("lat1_pc", id_pc, 32'h100);
    step(1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
    check_eq("stream_pc1", id_pc, 32'h104);
    check_eq("stream_rdy", 32'(if_ready), 32'd1);
    step(1'b1, 32'h108, 1'b1, 1'b0, 1'b0);
    check_eq("stream_pc2", id_pc, 32'h108);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_eq("stream_drained", 32'(id_valid), 32'd0);

    // 2: backpressure into FULL and release
    step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    check_eq("bp_if_ready", 32'(if_ready), 32'd0);
    check_eq("bp_hold_pc", id_pc, 32'h100);
    step(1'b1, 32'h108, 1'b0, 1'b0, 1'b0);
    check_eq("bp_hold_pc2", id_pc, 32'h100);
    check_eq("bp_hold_inst", id_inst, inst_of(32'h100));
    step(1'b1, 32'h108, 1'b1, 1'b0, 1'b0);
    check_eq("bp_rel_pc", id_pc, 32'h104);
    check_eq("bp_rel_rdy", 32'(if_ready), 32'd1);
    step(1'b1, 32'h108, 1'b1, 1'b0, 1'b0);
    check_eq("bp_rel_pc2", id_pc, 32'h108);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_eq("bp_sb_empty", 32'(sb.size()), 32'd0);

    // 3: flush while FULL, with a beat offered in the flush cycle
    step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
    check_reset_vals("flush");
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_eq("flush_no_200", 32'(id_valid), 32'd0);

    // 4: flush and reset together
    step(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h404, 1'b0, 1'b1, 1'b1);
    check_reset_vals("rstfl");
`ifdef IFID_STALL_CNT_EN
    check_eq("rstfl_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // 5: reset mid-stall, then first beat latency
    step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h504, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h508, 1'b0, 1'b0, 1'b1);
    check_reset_vals("rstfull");
    step(1'b1, 32'h50C, 1'b1, 1'b0, 1'b0);
    check_eq("post_rst_valid", 32'(id_valid), 32'd1);
    check_eq("post_rst_pc", id_pc, 32'h50C);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // random valid/ready traffic, checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 32'h1000 + 32'(i) * 32'd4,
           1'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
    end
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_eq("rand_sb_empty", 32'(sb.size()), 32'd0);
    check_eq("rand_idle", 32'(id_valid), 32'd0);

`ifdef IFID_STALL_CNT_EN
    // 6: counter saturation and flush immunity
    step(1'b1, 32'h600, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("stall_sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check_eq("stall_flush_keep", 32'(stall_cnt), 32'h0000_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
Name: if_id_pipe

Overview:
- Parametrised successor to the single-register IF/ID latch.
- Carries the fetched PC and instruction from the fetch stage to the decode stage over a valid/ready handshake.
- Adds a one-entry skid buffer so that the upstream ready is registered and contains no combinational path from decode.
- Adds a synchronous flush for branch/exception redirect; a flush kills every in-flight beat.

Parameters:
ADDR_W, 32, PC width in bits
INST_W, 32, instruction width in bits
NOP_INST, 0, instruction value driven when the output is invalid (reset/flush)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
flush  input  1  kill all held and incoming beats (redirect)
if_valid  input  1  fetch beat present
if_ready  output  1  stage can accept a beat; registered
if_pc  input  ADDR_W  fetch PC
if_inst  input  INST_W  fetched instruction
id_valid  output  1  decode beat present; registered
id_ready  input  1  decode accepts the beat
id_pc  output  ADDR_W  PC to decode; registered
id_inst  output  INST_W  instruction to decode; registered
stall_cnt  output  16  backpressure cycle count (only with IFID_STALL_CNT_EN)

Behaviour:
- Handshake definitions:
  - Upstream transfer (IN) = if_valid & if_ready.
  - Downstream transfer (OUT) = id_valid & id_ready.
  - All updates occur on the rising edge of clk.
- Storage:
  - Main register (drives the id_* outputs).
  - Skid register (sk_pc, sk_inst, sk_valid).
- if_ready = ~sk_valid, registered: it equals the complement of the skid-valid flop.
- States: EMPTY (id_valid=0, sk_valid=0), ONE (id_valid=1, sk_valid=0), FULL (id_valid=1, sk_valid=1).
- Transitions:
  - EMPTY, IN: main <= if_*; go to ONE.
  - EMPTY, no IN: stay EMPTY.
  - ONE, IN & OUT: main <= if_*; stay ONE (full throughput, one beat per cycle).
  - ONE, IN & ~OUT: skid <= if_*; go to FULL; if_ready drops next cycle.
  - ONE, ~IN & OUT: go to EMPTY; main payload is cleared to 0/NOP_INST.
  - ONE, ~IN & ~OUT: hold.
  - FULL, OUT: main <= skid; sk_valid <= 0; go to ONE. IN cannot occur because if_ready=0.
  - FULL, ~OUT: hold all state.
- Latency: 1 cycle from IN to id_valid when EMPTY or when ONE with a simultaneous OUT. Beats are strictly in order; none is dropped or duplicated except by flush.
- Flush:
  - Priority: rst > flush > handshake.
  - Next cycle: id_valid=0, sk_valid=0, if_ready=1, id_pc=0, id_inst=NOP_INST.
  - A beat offered in the flush cycle is discarded even if if_valid=1. if_ready in that cycle still reflects the old state, but no IN is recorded.
  - A flush in FULL discards both beats.
- Reset (any state, including mid-transfer): id_valid=0, sk_valid=0, if_ready=1, id_pc=0, id_inst=NOP_INST, skid payload=0; stall_cnt=0 if present.
- Payload while id_valid=0 is always 0 (PC) and NOP_INST (instruction); decode must never see stale data.
- Payload while id_valid=1 & ~OUT is stable (no change until OUT).
- Ports are not widened or truncated; all payloads are exactly ADDR_W and INST_W bits.

Optional Feature:
- Macro: IFID_STALL_CNT_EN.
- When defined:
  - stall_cnt port exists.
  - Increments each cycle with id_valid & ~id_ready.
  - Saturates at 16'hFFFF.
  - Cleared only by rst; flush does not clear it.
- When undefined: the port and counter logic are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - default ADDR_W and INST_W;
  - NOP_INST (ZeroWord);
  - state encodings EMPTY/ONE/FULL;
  - RstEnable level.
- One natural sub-module: pipe_skid_slot, a generic width-parametrised data+valid skid register with load/clear.
- if_id_pipe instantiates pipe_skid_slot once, combined with the main register and control.

Test Plan:
1. Reset then streaming: rst=1 for 2 cycles, then if_valid=1 with PCs 0x100, 0x104, 0x108 and id_ready=1 → id_valid rises 1 cycle after the first beat; id_pc follows 0x100, 0x104, 0x108 on consecutive cycles; if_ready stays 1.
2. Backpressure: stream beats with id_ready=0 from cycle 3 → cycle 3 goes to FULL and if_ready=0 on the next cycle; id_pc holds 0x100; release id_ready → 0x104 then 0x108 delivered, no loss, if_ready returns to 1.
3. Flush in FULL: FULL state plus flush=1 with if_valid=1 and PC 0x200 → next cycle id_valid=0, id_inst=0, id_pc=0, if_ready=1; 0x200 never appears at the output.
4. Flush vs. reset priority: flush=1 and rst=1 in the same cycle → reset values; with IFID_STALL_CNT_EN, stall_cnt=0.
5. Reset mid-stall: FULL state plus rst=1 → next cycle EMPTY, all outputs at reset values; the first beat after reset has 1-cycle latency.
6. Stall counter (IFID_STALL_CNT_EN): hold id_valid=1, id_ready=0 for 70000 cycles → stall_cnt=16'hFFFF and stays there; a flush does not change it.
